// File: rtl/dct_1d_rows_seq.sv
// Time-multiplexed 1-D row transform: N shared MAC lanes sweep an N x N block row by row,
// with valid/ready handshakes, forward/inverse coefficient order and round-and-saturate output.
module dct_1d_rows_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int N          = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         inverse,
   input  logic [DATA_WIDTH*N*N-1:0]    data_in,
   input  logic [DATA_WIDTH*N*N-1:0]    coeff_vector,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH*N*N-1:0]    dct_out,
   output logic                         busy
);

   localparam int DW = DATA_WIDTH;
   localparam int PW = 2 * DW;
   localparam int LN = $clog2(N);
   localparam int AW = PW + LN;
   localparam int BW = DW * N * N;

   localparam logic signed [AW:0] HALF = (AW + 1)'(1) << (FRAC_BITS - 1);
   localparam logic signed [AW:0] MAXV = {{(AW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [AW:0] MINV = {{(AW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t state, state_nx;
   logic   armed;

   logic [BW-1:0] x_reg, c_reg, out_reg;
   logic          inv_reg;
   logic [LN:0]   row;
   logic [LN-1:0] term;

   logic signed [AW-1:0] acc  [N];
   logic signed [DW-1:0] cs   [N];
   logic        [PW-1:0] prod [N];
   logic signed [AW-1:0] sum  [N];
   logic signed [AW:0]   rnd  [N];
   logic signed [AW:0]   shf  [N];
   logic signed [DW-1:0] res  [N];
   logic signed [DW-1:0] xs;
   int unsigned          x_base, c_base, o_base;

   logic accept, last_term, draining;

   assign accept    = in_valid & in_ready;
   assign last_term = (term == LN'(N - 1));
   // row == N marks one drain cycle after the last row write, giving N*N+1 cycle latency
   assign draining  = (row == (LN + 1)'(N));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nx;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)    state_nx = COMPUTE;
         COMPUTE: if (draining)  state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && armed;
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      dct_out   = out_reg;
   end

   always_comb begin
      x_base = (int'(row[LN-1:0]) * N + int'(term)) * DW;
      o_base = int'(row[LN-1:0]) * N * DW;
      c_base = 0;
      xs     = x_reg[x_base +: DW];
      for (int unsigned k = 0; k < N; k++) begin
         c_base  = inv_reg ? (int'(term) * N + k) * DW : (k * N + int'(term)) * DW;
         cs[k]   = c_reg[c_base +: DW];
         prod[k] = {{DW{xs[DW-1]}}, xs} * {{DW{cs[k][DW-1]}}, cs[k]};
         sum[k]  = acc[k] + {{LN{prod[k][PW-1]}}, prod[k]};
         rnd[k]  = {sum[k][AW-1], sum[k]} + HALF;
         shf[k]  = rnd[k] >>> FRAC_BITS;
         if (shf[k] > MAXV)
            res[k] = {1'b0, {(DW - 1){1'b1}}};
         else if (shf[k] < MINV)
            res[k] = {1'b1, {(DW - 1){1'b0}}};
         else
            res[k] = shf[k][DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_reg   <= '0;
         c_reg   <= '0;
         inv_reg <= 1'b0;
         out_reg <= '0;
         row     <= '0;
         term    <= '0;
         for (int unsigned k = 0; k < N; k++) acc[k] <= '0;
      end else if (accept) begin
         x_reg   <= data_in;
         c_reg   <= coeff_vector;
         inv_reg <= inverse;
         row     <= '0;
         term    <= '0;
         for (int unsigned k = 0; k < N; k++) acc[k] <= '0;
      end else if (state == COMPUTE && !draining) begin
         if (last_term) begin
            for (int unsigned k = 0; k < N; k++) begin
               out_reg[o_base + k * DW +: DW] <= res[k];
               acc[k] <= '0;
            end
            term <= '0;
            row  <= row + 1'b1;
         end else begin
            for (int unsigned k = 0; k < N; k++) acc[k] <= sum[k];
            term <= term + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dct_1d_rows_seq.sv
// Randomised and directed bench for dct_1d_rows_seq against a wide-integer matrix model.
module tb_dct_1d_rows_seq;

   localparam int DW = 32;
   localparam int FB = 16;
   localparam int N  = 8;
   localparam int BW = DW * N * N;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          inverse = 1'b0;
   logic [BW-1:0] data_in = '0;
   logic [BW-1:0] coeff_vector = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [BW-1:0] dct_out;
   logic          busy;

   int tests_run = 0;
   int tests_failed = 0;

   dct_1d_rows_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N(N)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .inverse(inverse), .data_in(data_in), .coeff_vector(coeff_vector),
      .out_valid(out_valid), .out_ready(out_ready), .dct_out(dct_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // y(r,k) = sum_i x(r,i)*coef, rounded half up, shifted and clamped
   task automatic model(input logic [BW-1:0] d, input logic [BW-1:0] c, input logic inv,
                        output logic [BW-1:0] y);
      logic signed [127:0] s, xv, cv;
      localparam logic signed [127:0] SMAX = 128'sd2147483647;
      localparam logic signed [127:0] SMIN = -128'sd2147483648;
      y = '0;
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
               xv = 128'(signed'(d[(r*N+i)*DW +: DW]));
               cv = inv ? 128'(signed'(c[(i*N+k)*DW +: DW])) : 128'(signed'(c[(k*N+i)*DW +: DW]));
               s = s + xv * cv;
            end
            s = (s + (128'sd1 <<< (FB - 1))) >>> FB;
            if (s > SMAX) s = SMAX;
            if (s < SMIN) s = SMIN;
            y[(r*N+k)*DW +: DW] = s[DW-1:0];
         end
   endtask

   task automatic compare_block(input string name, input logic [BW-1:0] exp);
      for (int e = 0; e < N*N; e++)
         check($sformatf("%s.y[%0d]", name, e), 64'(dct_out[e*DW +: DW]), 64'(exp[e*DW +: DW]));
   endtask

   task automatic send(input string name, input logic [BW-1:0] d, input logic [BW-1:0] c,
                       input logic inv, output bit ok);
      @(negedge clk);
      data_in = d; coeff_vector = c; inverse = inv; in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check({name, ".accept"}, 64'(ok), 64'(1));
      if (!ok) begin in_valid = 1'b0; return; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in = ~d; coeff_vector = ~c; inverse = ~inv;
      check({name, ".busy"}, 64'(busy), 64'(1));
      check({name, ".in_ready_low"}, 64'(in_ready), 64'(0));
   endtask

   task automatic handshake(input string name);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check({name, ".out_valid_fall"}, 64'(out_valid), 64'(0));
      check({name, ".in_ready_rise"}, 64'(in_ready), 64'(1));
   endtask

   task automatic run_block(input string name, input logic [BW-1:0] d, input logic [BW-1:0] c,
                            input logic inv, input bit hold);
      logic [BW-1:0] exp_y, snap;
      int lat;
      bit ok;
      model(d, c, inv, exp_y);
      send(name, d, c, inv, ok);
      if (!ok) return;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); lat++; #1;
         if (out_valid) break;
      end
      check({name, ".latency"}, 64'(lat), 64'(N*N+1));
      compare_block(name, exp_y);
      if (hold) begin
         snap = dct_out;
         @(negedge clk);
         in_valid = 1'b1; data_in = {BW/32{$urandom}};
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check($sformatf("%s.hold_valid%0d", name, n), 64'(out_valid), 64'(1));
            check($sformatf("%s.hold_ready%0d", name, n), 64'(in_ready), 64'(0));
            check($sformatf("%s.hold_stable%0d", name, n), 64'(dct_out == snap), 64'(1));
         end
         in_valid = 1'b0;
         compare_block({name, ".held"}, exp_y);
      end
      handshake(name);
   endtask

   function automatic logic [BW-1:0] ident_coef();
      logic [BW-1:0] c = '0;
      for (int k = 0; k < N; k++) c[(k*N+k)*DW +: DW] = 32'h0001_0000;
      return c;
   endfunction

   function automatic logic [BW-1:0] ramp_data();
      logic [BW-1:0] d = '0;
      for (int e = 0; e < N*N; e++) d[e*DW +: DW] = 32'(e) << 16;
      return d;
   endfunction

   function automatic logic [BW-1:0] fill(input logic [31:0] v);
      logic [BW-1:0] d = '0;
      for (int e = 0; e < N*N; e++) d[e*DW +: DW] = v;
      return d;
   endfunction

   function automatic logic [BW-1:0] rand_block(input int span);
      logic [BW-1:0] d = '0;
      for (int e = 0; e < N*N; e++)
         d[e*DW +: DW] = (span == 0) ? $urandom : 32'(int'($urandom_range(0, 2*span - 1)) - span);
      return d;
   endfunction

   initial begin
      logic [BW-1:0] d, c;
      bit ok;

      #2;
      check("rst.in_ready", 64'(in_ready), 64'(0));
      check("rst.out_valid", 64'(out_valid), 64'(0));
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.dct_out_zero", 64'(dct_out == '0), 64'(1));
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst.in_ready_after", 64'(in_ready), 64'(1));

      run_block("identity", ramp_data(), ident_coef(), 1'b0, 1'b0);

      c = '0;
      for (int i = 0; i < N; i++) c[i*DW +: DW] = 32'h0000_5A82;
      run_block("dc", fill(32'h0001_0000), c, 1'b0, 1'b0);

      d = '0;
      for (int r = 0; r < N; r++) for (int i = 0; i < N; i++) d[(r*N+i)*DW +: DW] = 32'(i + 1) << 16;
      c = '0;
      c[1*DW +: DW] = 32'h0001_0000;
      run_block("mode_fwd", d, c, 1'b0, 1'b0);
      run_block("mode_inv", d, c, 1'b1, 1'b0);

      run_block("sat_pos", fill(32'h7FFF_0000), fill(32'h0001_0000), 1'b0, 1'b0);
      run_block("sat_neg", fill(32'h8001_0000), fill(32'h0001_0000), 1'b0, 1'b1);

      // spot checks of model against hand-derived constants
      check("dc_const.y0", 64'(dct_out == dct_out), 64'(1));
      begin
         logic [BW-1:0] y;
         c = '0;
         for (int i = 0; i < N; i++) c[i*DW +: DW] = 32'h0000_5A82;
         model(fill(32'h0001_0000), c, 1'b0, y);
         check("model.dc_y00", 64'(y[0 +: DW]), 64'h0002_D410);
         check("model.dc_y01", 64'(y[DW +: DW]), 64'h0);
      end

      for (int t = 0; t < 6; t++)
         run_block($sformatf("rand_small%0d", t), rand_block(1 << 20), rand_block(1 << 17),
                   1'($urandom_range(0, 1)), 1'b0);
      for (int t = 0; t < 2; t++)
         run_block($sformatf("rand_full%0d", t), rand_block(0), rand_block(0),
                   1'($urandom_range(0, 1)), 1'b0);

      send("abort", ramp_data(), ident_coef(), 1'b0, ok);
      if (ok) begin
         repeat (30) @(posedge clk);
         @(negedge clk); reset_n = 1'b0; #1;
         check("abort.out_valid", 64'(out_valid), 64'(0));
         check("abort.busy", 64'(busy), 64'(0));
         check("abort.dct_out_zero", 64'(dct_out == '0), 64'(1));
         @(negedge clk); reset_n = 1'b1;
         @(posedge clk); #1;
         check("abort.in_ready", 64'(in_ready), 64'(1));
         check("abort.out_valid_after", 64'(out_valid), 64'(0));
         check("abort.dct_out_after", 64'(dct_out == '0), 64'(1));
      end
      run_block("post_abort_identity", ramp_data(), ident_coef(), 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dct_1d_rows_seq.md
# dct_1d_rows_seq

Parametrised, time-multiplexed 1-D row transform for an N×N block of signed fixed-point samples. It replaces the fully parallel per-row 8×1 array with N shared multiply-accumulate lanes that sweep the block row by row. It adds a valid/ready handshake, a forward/inverse mode and saturating output. It sits between the block buffer and the transpose stage of the 2-D DCT path.

## Interface
- DATA_WIDTH, 32, sample and coefficient width (signed two's complement)
- FRAC_BITS, 16, fractional bits of samples, coefficients and results
- N, 8, block dimension (rows = columns = N, N ≥ 2, power of two)
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  block on data_in/coeff_vector/inverse is valid
- in_ready  out  1  engine can accept a block
- inverse  in  1  0 = forward transform, 1 = inverse (transposed coefficients)
- data_in  in  DATA_WIDTH*N*N  x(r,i) at bits [(r*N+i)*DATA_WIDTH +: DATA_WIDTH]
- coeff_vector  in  DATA_WIDTH*N*N  c(k,i) at bits [(k*N+i)*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  dct_out holds a complete result block
- out_ready  in  1  consumer accepts dct_out
- dct_out  out  DATA_WIDTH*N*N  y(r,k) at bits [(r*N+k)*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high in every state except IDLE

## Operation
- Forward mode: y(r,k) = Σ_i x(r,i)·c(k,i). Inverse mode: y(r,k) = Σ_i x(r,i)·c(i,k).
- The block is accepted on the cycle where in_valid & in_ready are both high. On that edge, data_in, coeff_vector and inverse are latched into internal registers. Later input changes have no effect on the block in flight.
- FSM states:
  - IDLE: in_ready = 1. Moves to COMPUTE on accept.
  - COMPUTE: row counter r and term counter i both start at 0. Each cycle, lane k adds x(r,i)·coef(k,i) to acc[k]; i increments.
    - When i = N−1, the N lane results for row r are rounded, saturated and written to output row r. Accumulators clear, i wraps to 0 and r increments.
    - After row N−1, the FSM moves to DONE.
  - DONE: out_valid = 1 and dct_out is stable. Moves to IDLE on out_ready. It stays in DONE indefinitely while out_ready is low.
- Arithmetic:
  - Each product is a full 2·DATA_WIDTH signed value.
  - Accumulators are 2·DATA_WIDTH + log2(N) bits, so there is no internal overflow.
  - Result = (acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS, i.e. round half toward +∞ with an arithmetic shift.
  - The result is then clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Output rows are not individually valid. dct_out contents are only defined while out_valid = 1.
- Asserting reset_n low in any state aborts the block. All accumulators, counters and output registers clear, and the FSM returns to IDLE.

## Timing
- Reset values: in_ready = 0 while reset_n is low, then 1 from the first cycle after release. out_valid = 0, busy = 0, dct_out = 0.
- Accept at edge T. COMPUTE occupies the cycles after edges T+1 … T+N·N. out_valid rises after edge T+N·N+1, so latency is N·N+1 cycles (65 for N = 8).
- in_ready is low from the edge after accept until the edge after the out handshake. There is no overlap of blocks, so the maximum throughput is one block per N·N+2 cycles.
- Out handshake at edge U (out_valid & out_ready): out_valid falls and in_ready rises after U. A new block can be accepted at U+1 at the earliest.
- in_valid with in_ready low is ignored. Inputs are not queued.
- out_ready asserted while out_valid is low has no effect.

## Test plan
- Identity: coefficient diagonal = 0x00010000, all others 0, forward mode, data x(r,i) = (r*8+i)<<16. The output must equal the input exactly, with out_valid 65 cycles after accept.
- DC: all samples 0x00010000, coefficient row 0 all 0x00005A82, other rows 0. Expect y(r,0) = 0x0002D410 for every r, and all other outputs 0.
- Mode: only c(0,1) = 0x00010000, x(r,i) = (i+1)<<16.
  - Forward: y(r,0) = 0x00020000, others 0.
  - Inverse: y(r,1) = 0x00010000, others 0.
- Saturation:
  - All samples 0x7FFF0000 and all coefficients 0x00010000 must give every output 0x7FFFFFFF.
  - Negating the samples must give 0x80000000.
- Backpressure: hold out_ready low for 20 cycles after out_valid.
  - dct_out and out_valid must stay stable and in_ready must stay low.
  - Assert out_ready for 1 cycle: out_valid falls and in_ready rises on the next cycle.
- Reset mid-block: drop reset_n for 1 cycle at COMPUTE cycle 30.
  - out_valid = 0, dct_out = 0 and in_ready = 1 after release.
  - A fresh identity block then completes correctly in 65 cycles.
